multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the RV32I datapath. It replaces the single-cycle opcode decoder and its separate ALU-control decoder with one FSM. The FSM sequences fetch, decode, execute, memory and write-back over several cycles, stalls on a memory ready handshake and fully decodes funct3/funct7 to ALU operations. The block sits between the instruction/data memory port and the datapath muxes, register file and ALU.

---
 rtl/ctrl_pkg.sv | 97 +++++++++
 rtl/multicycle_ctrl_if.sv | 29 ++
 rtl/alu_op_dec.sv | 59 +++++
 rtl/multicycle_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the RV32I multi-cycle control unit:
//   - FSM state encoding and decoded instruction classes
//   - RV32I opcode / funct7 constants
//   - ALU operation codes
//   - datapath mux encodings (ALU operand A/B, write-back source)
//   - classify(): full legality decode of opcode/funct3/funct7 into a class
// Optional feature macro: RV32M_EN (makes the M-extension encoding legal).
// -----------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_MDWAIT, ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_LUI, CL_AUIPC,
    CL_BRANCH, CL_JAL, CL_JALR, CL_MULDIV, CL_ILLEGAL
  } opclass_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS1   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;
  localparam logic [1:0] SRC_A_ZERO  = 2'd3;

  localparam logic [1:0] SRC_B_RS2   = 2'd0;
  localparam logic [1:0] SRC_B_FOUR  = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;

  localparam logic [1:0] WB_ALUOUT   = 2'd0;
  localparam logic [1:0] WB_MDR      = 2'd1;
  localparam logic [1:0] WB_PC       = 2'd2;
  localparam logic [1:0] WB_MD       = 2'd3;

  // addi x0,x0,0 -- the instruction register comes out of reset holding a NOP.
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  // Anything not a defined RV32I (or, when enabled, RV32M) encoding is
  // CL_ILLEGAL so that DECODE can divert it to TRAP.
  function automatic opclass_e classify(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
    opclass_e cls;
    cls = CL_ILLEGAL;
    case (opcode)
      OPC_R: begin
        if (funct7 == F7_BASE) cls = CL_R;
        else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) cls = CL_R;
`ifdef RV32M_EN
        else if (funct7 == F7_MULDIV) cls = CL_MULDIV;
`endif
      end
      OPC_I: begin
        if (funct3 == 3'b001) cls = (funct7 == F7_BASE) ? CL_I : CL_ILLEGAL;
        else if (funct3 == 3'b101)
          cls = (funct7 == F7_BASE || funct7 == F7_ALT) ? CL_I : CL_ILLEGAL;
        else cls = CL_I;
      end
      OPC_LOAD:   cls = (funct3 == 3'b011 || funct3[2:1] == 2'b11) ? CL_ILLEGAL : CL_LOAD;
      OPC_STORE:  cls = (funct3[2] || funct3[1:0] == 2'b11) ? CL_ILLEGAL : CL_STORE;
      OPC_LUI:    cls = CL_LUI;
      OPC_AUIPC:  cls = CL_AUIPC;
      OPC_BRANCH: cls = (funct3[2:1] == 2'b01) ? CL_ILLEGAL : CL_BRANCH;
      OPC_JAL:    cls = CL_JAL;
      OPC_JALR:   cls = (funct3 == 3'b000) ? CL_JALR : CL_ILLEGAL;
      default:    cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Instruction/data memory port between the control unit and memory.
//   mem_rdata : read data (captured as the instruction in FETCH)
//   mem_ready : access completes this cycle
//   mem_req   : access request
//   mem_we    : store request, meaningful only with mem_req
//   addr_sel  : address source, 0 = PC, 1 = ALUOut
// Modports: master (control unit), slave (memory).
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;
  logic            mem_req;
  logic            mem_we;
  logic            addr_sel;

  modport master (
    input  mem_rdata, mem_ready,
    output mem_req, mem_we, addr_sel
  );

  modport slave (
    output mem_rdata, mem_ready,
    input  mem_req, mem_we, addr_sel
  );
endinterface

// File: rtl/alu_op_dec.sv
// -----------------------------------------------------------------------------
// alu_op_dec
// Combinational ALU-operation decoder used in EXEC.
//   cls_i      : decoded instruction class
//   funct3_i   : ir[14:12]
//   ir30_i     : ir[30], selects SUB / SRA(I)
//   funct7_i   : ir[31:25]
//   alu_ctrl_o : ALU operation code
// -----------------------------------------------------------------------------
module alu_op_dec
  import ctrl_pkg::*;
(
  input  opclass_e   cls_i,
  input  logic [2:0] funct3_i,
  input  logic       ir30_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_ctrl_o
);

  logic alt_op;
  logic [3:0] arith_code;

  // ir[30] picks the alternate operation; the other funct7 bits are clear for
  // every legal alternate encoding.
  assign alt_op = ir30_i && (funct7_i == F7_ALT);

  always_comb begin
    arith_code = ALU_ADD;
    case (funct3_i)
      3'b000: arith_code = (cls_i == CL_R && alt_op) ? ALU_SUB : ALU_ADD;
      3'b001: arith_code = ALU_SLL;
      3'b010: arith_code = ALU_SLT;
      3'b011: arith_code = ALU_SLTU;
      3'b100: arith_code = ALU_XOR;
      3'b101: arith_code = alt_op ? ALU_SRA : ALU_SRL;
      3'b110: arith_code = ALU_OR;
      3'b111: arith_code = ALU_AND;
      default: arith_code = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (cls_i)
      CL_R, CL_I: alu_ctrl_o = arith_code;
      // beq/bne test equality, blt/bge signed, bltu/bgeu unsigned compare.
      CL_BRANCH: begin
        case (funct3_i[2:1])
          2'b00:   alu_ctrl_o = ALU_SUB;
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//   clk, rst     : clock, asynchronous active-high reset
//   mem          : memory port (multicycle_ctrl_if.master)
//   alu_zero     : ALU result is zero (branch resolution)
//   md_done      : mul/div result valid
//   ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl,
//   reg_write, wb_sel, md_start : datapath controls, decoded from state/ir
//   illegal      : sticky illegal-instruction flag
//   ir           : latched instruction
// Optional feature macro: RV32M_EN (mul/div sequencing through MDWAIT).
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_if.master     mem,
  input  logic                  alu_zero,
  input  logic                  md_done,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  reg_write,
  output logic [1:0]            wb_sel,
  output logic                  md_start,
  output logic                  illegal,
  output logic [XLEN-1:0]       ir
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] ir_q;
  logic            illegal_q;
  opclass_e        cls;
  logic [3:0]      dec_code;
  logic [3:0]      alu_code;

  assign cls = classify(ir_q[6:0], ir_q[14:12], ir_q[31:25]);

  alu_op_dec u_alu_op_dec (
    .cls_i      (cls),
    .funct3_i   (ir_q[14:12]),
    .ir30_i     (ir_q[30]),
    .funct7_i   (ir_q[31:25]),
    .alu_ctrl_o (dec_code)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      ir_q      <= XLEN'(NOP_INSTR);
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ir_write) ir_q <= mem.mem_rdata;
      if (state_d == ST_TRAP) illegal_q <= 1'b1;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RS2;
    alu_code     = ALU_AND;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    md_start     = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_FOUR;
        alu_code    = ALU_ADD;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      // Speculatively form old PC + imm so branches/JAL find their target in ALUOut.
      ST_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_code  = ALU_ADD;
        state_d   = (cls == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
      end

      ST_EXEC: begin
        alu_code = dec_code;
        case (cls)
          CL_R:     begin alu_src_a = SRC_A_RS1;   alu_src_b = SRC_B_RS2; state_d = ST_WB;  end
          CL_I:     begin alu_src_a = SRC_A_RS1;   alu_src_b = SRC_B_IMM; state_d = ST_WB;  end
          CL_LOAD,
          CL_STORE: begin alu_src_a = SRC_A_RS1;   alu_src_b = SRC_B_IMM; state_d = ST_MEM; end
          CL_LUI:   begin alu_src_a = SRC_A_ZERO;  alu_src_b = SRC_B_IMM; state_d = ST_WB;  end
          CL_AUIPC: begin alu_src_a = SRC_A_OLDPC; alu_src_b = SRC_B_IMM; state_d = ST_WB;  end
          CL_BRANCH: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            pc_src    = 1'b1;
            // beq/bge/bgeu take on zero, bne/blt/bltu on non-zero.
            pc_write  = alu_zero ^ ir_q[12] ^ ir_q[14];
            state_d   = ST_FETCH;
          end
          CL_JAL: begin
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            reg_write = 1'b1;
            wb_sel    = WB_PC;
            state_d   = ST_FETCH;
          end
          CL_JALR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            wb_sel    = WB_PC;
            state_d   = ST_FETCH;
          end
`ifdef RV32M_EN
          CL_MULDIV: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            md_start  = 1'b1;
            state_d   = ST_MDWAIT;
          end
`endif
          default: state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        mem.mem_we   = (cls == CL_STORE);
        if (mem.mem_ready) state_d = (cls == CL_LOAD) ? ST_WB : ST_FETCH;
      end

      ST_WB: begin
        reg_write = 1'b1;
        if (cls == CL_LOAD)        wb_sel = WB_MDR;
        else if (cls == CL_MULDIV) wb_sel = WB_MD;
        else                       wb_sel = WB_ALUOUT;
        state_d = ST_FETCH;
      end

`ifdef RV32M_EN
      ST_MDWAIT: if (md_done) state_d = ST_WB;
`else
      ST_MDWAIT: state_d = ST_TRAP;
`endif

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_RESET;
    endcase

    alu_ctrl = ALU_CTRL_W'(alu_code);
  end

`ifndef RV32M_EN
  logic unused_md_done;
  assign unused_md_done = md_done;
`endif

  assign illegal = illegal_q;
  assign ir      = ir_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl. Inputs change just after the falling
// edge and outputs are sampled 1 time unit later. All control outputs are
// packed into one 19-bit signature {mem_req, mem_we, addr_sel, ir_write,
// pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, wb_sel,
// md_start, illegal}; fields a state leaves unspecified are masked out.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] SLT = 4'b0111;
  localparam logic [3:0] SRA = 4'b1001;

  localparam logic [1:0] A_PC = 2'd0, A_RS1 = 2'd1, A_OLDPC = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2;

  localparam logic [31:0] I_ADDI5    = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_SUB      = 32'h4020_81B3; // sub  x3,x1,x2
  localparam logic [31:0] I_LW       = 32'h0080_A283; // lw   x5,8(x1)
  localparam logic [31:0] I_SW       = 32'h0050_A623; // sw   x5,12(x1)
  localparam logic [31:0] I_BGE      = 32'h0020_D463; // bge  x1,x2,+8
  localparam logic [31:0] I_ADDI1024 = 32'h4000_0093; // addi x1,x0,1024 (ir[30]=1)
  localparam logic [31:0] I_SRAI     = 32'h4030_D093; // srai x1,x1,3
  localparam logic [31:0] I_BAD      = 32'h0000_007F; // unknown opcode
  localparam logic [31:0] I_MUL      = 32'h0220_81B3; // mul  x3,x1,x2

  localparam logic [18:0] CARE_ALL    = 19'h7FFFF;
  localparam logic [18:0] CARE_NO_ALU = 19'h7FFFF & ~19'h01FE0;
  localparam logic [18:0] CARE_NO_PCS = 19'h7FFFF & ~19'h02000;
  localparam logic [31:0] CARE_W      = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic alu_zero, md_done;
  logic ir_write, pc_write, pc_src, reg_write, md_start, illegal;
  logic [1:0] alu_src_a, alu_src_b, wb_sel;
  logic [3:0] alu_ctrl;
  logic [31:0] ir;

  multicycle_ctrl_if #(.XLEN(32)) mem_if ();

  multicycle_ctrl #(.XLEN(32), .ALU_CTRL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (mem_if),
    .alu_zero  (alu_zero),
    .md_done   (md_done),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_ctrl  (alu_ctrl),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .md_start  (md_start),
    .illegal   (illegal),
    .ir        (ir)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int unsigned start_cyc = 0;

  function automatic logic [18:0] sig();
    return {mem_if.mem_req, mem_if.mem_we, mem_if.addr_sel, ir_write, pc_write,
            pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, wb_sel, md_start, illegal};
  endfunction

  function automatic logic [18:0] E(bit req, bit we, bit asel, bit irw, bit pcw, bit pcs,
                                    logic [1:0] a, logic [1:0] b, logic [3:0] alu,
                                    bit rw, logic [1:0] wbs, bit mds, bit ill);
    return {req, we, asel, irw, pcw, pcs, a, b, alu, rw, wbs, mds, ill};
  endfunction

  localparam logic [18:0] S_ZERO = 19'h0;
  logic [18:0] f_wait, f_rdy, s_dec;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp, input logic [31:0] care);
    n_cmp++;
    assert ((obs & care) === (exp & care)) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs & care, exp & care);
    end
  endtask

  task automatic chk_sig(input string tag, input logic [18:0] exp, input logic [18:0] care);
    check(tag, {13'b0, sig()}, {13'b0, exp}, {13'b0, care});
  endtask

  task automatic step(input string tag, input bit rdy, input bit zero, input bit done,
                      input logic [18:0] exp, input logic [18:0] care);
    @(negedge clk);
    mem_if.mem_ready = rdy;
    alu_zero         = zero;
    md_done          = done;
    #1;
    chk_sig(tag, exp, care);
  endtask

  // Runs the FETCH cycles of one instruction. On its first cycle it also
  // checks the length of the previous instruction (prev_len > 0).
  task automatic do_fetch(input string tag, input logic [31:0] instr, input int waits,
                          input int prev_len, input logic [31:0] prev_ir);
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      alu_zero = 1'b0;
      md_done  = 1'b0;
      if (w < waits) begin
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'hDEAD_BEEF;
      end else begin
        mem_if.mem_ready = 1'b1;
        mem_if.mem_rdata = instr;
      end
      #1;
      if (w == 0) begin
        if (prev_len > 0) check({tag, " prev instr cycles"}, cyc - start_cyc, prev_len, CARE_W);
        start_cyc = cyc;
      end
      if (w < waits) begin
        chk_sig({tag, " fetch wait"}, f_wait, CARE_ALL);
        check({tag, " ir held"}, ir, prev_ir, CARE_W);
      end else begin
        chk_sig({tag, " fetch ready"}, f_rdy, CARE_ALL);
      end
    end
  endtask

  task automatic do_decode(input string tag, input bit rdy, input logic [31:0] instr);
    step({tag, " decode"}, rdy, 1'b0, 1'b0, s_dec, CARE_ALL);
    check({tag, " ir"}, ir, instr, CARE_W);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    f_wait = E(1,0,0,0,0,0, A_PC, B_FOUR, ADD, 0, 2'd0, 0, 0);
    f_rdy  = E(1,0,0,1,1,0, A_PC, B_FOUR, ADD, 0, 2'd0, 0, 0);
    s_dec  = E(0,0,0,0,0,0, A_OLDPC, B_IMM, ADD, 0, 2'd0, 0, 0);

    rst = 1'b1;
    alu_zero = 1'b0;
    md_done = 1'b0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk_sig("reset outputs", S_ZERO, CARE_ALL);
    check("reset ir", ir, 32'h0000_0013, CARE_W);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_sig("reset state after release", S_ZERO, CARE_ALL);

    // addi with mem_ready held high throughout
    do_fetch("addi", I_ADDI5, 0, 0, 32'h0);
    do_decode("addi", 1'b1, I_ADDI5);
    step("addi exec", 1, 0, 0, E(0,0,0,0,0,0, A_RS1, B_IMM, ADD, 0, 2'd0, 0, 0), CARE_ALL);
    step("addi wb",   1, 0, 0, E(0,0,0,0,0,0, 2'd0, 2'd0, 4'd0, 1, 2'd0, 0, 0), CARE_NO_ALU);

    // sub with two fetch wait cycles
    do_fetch("sub", I_SUB, 2, 4, I_ADDI5);
    do_decode("sub", 1'b0, I_SUB);
    step("sub exec", 0, 0, 0, E(0,0,0,0,0,0, A_RS1, B_RS2, SUB, 0, 2'd0, 0, 0), CARE_ALL);
    step("sub wb",   0, 0, 0, E(0,0,0,0,0,0, 2'd0, 2'd0, 4'd0, 1, 2'd0, 0, 0), CARE_NO_ALU);

    do_fetch("lw", I_LW, 0, 6, 32'h0);
    do_decode("lw", 1'b0, I_LW);
    step("lw exec", 0, 0, 0, E(0,0,0,0,0,0, A_RS1, B_IMM, ADD, 0, 2'd0, 0, 0), CARE_ALL);
    step("lw mem",  1, 0, 0, E(1,0,1,0,0,0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 0, 0), CARE_NO_ALU);
    step("lw wb",   0, 0, 0, E(0,0,0,0,0,0, 2'd0, 2'd0, 4'd0, 1, 2'd1, 0, 0), CARE_NO_ALU);

    do_fetch("sw", I_SW, 0, 5, 32'h0);
    do_decode("sw", 1'b0, I_SW);
    step("sw exec", 0, 0, 0, E(0,0,0,0,0,0, A_RS1, B_IMM, ADD, 0, 2'd0, 0, 0), CARE_ALL);
    step("sw mem",  1, 0, 0, E(1,1,1,0,0,0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 0, 0), CARE_NO_ALU);

    do_fetch("bge taken", I_BGE, 0, 4, 32'h0);
    do_decode("bge taken", 1'b0, I_BGE);
    step("bge taken exec", 0, 1, 0, E(0,0,0,0,1,1, A_RS1, B_RS2, SLT, 0, 2'd0, 0, 0), CARE_ALL);

    do_fetch("bge not taken", I_BGE, 0, 3, 32'h0);
    do_decode("bge not taken", 1'b0, I_BGE);
    step("bge not taken exec", 0, 0, 0, E(0,0,0,0,0,0, A_RS1, B_RS2, SLT, 0, 2'd0, 0, 0), CARE_NO_PCS);

    // addi whose immediate sets ir[30] must still add
    do_fetch("addi 1024", I_ADDI1024, 0, 3, 32'h0);
    do_decode("addi 1024", 1'b0, I_ADDI1024);
    step("addi 1024 exec", 0, 0, 0, E(0,0,0,0,0,0, A_RS1, B_IMM, ADD, 0, 2'd0, 0, 0), CARE_ALL);
    step("addi 1024 wb",   0, 0, 0, E(0,0,0,0,0,0, 2'd0, 2'd0, 4'd0, 1, 2'd0, 0, 0), CARE_NO_ALU);

    // srai, with mem_ready high in DECODE/EXEC where it must be ignored
    do_fetch("srai", I_SRAI, 0, 4, 32'h0);
    do_decode("srai", 1'b1, I_SRAI);
    step("srai exec", 1, 0, 0, E(0,0,0,0,0,0, A_RS1, B_IMM, SRA, 0, 2'd0, 0, 0), CARE_ALL);
    step("srai wb",   1, 0, 0, E(0,0,0,0,0,0, 2'd0, 2'd0, 4'd0, 1, 2'd0, 0, 0), CARE_NO_ALU);

    do_fetch("illegal", I_BAD, 0, 4, 32'h0);
    do_decode("illegal", 1'b0, I_BAD);
    for (int i = 0; i < 3; i++)
      step("trap", 1, 0, 0, E(0,0,0,0,0,0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 0, 1), CARE_NO_ALU);

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_sig("trap reset outputs", S_ZERO, CARE_ALL);
    check("trap reset ir", ir, 32'h0000_0013, CARE_W);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_sig("trap reset state", S_ZERO, CARE_ALL);

    do_fetch("mul", I_MUL, 0, 0, 32'h0);
    do_decode("mul", 1'b0, I_MUL);
`ifdef RV32M_EN
    step("mul exec", 0, 0, 0, E(0,0,0,0,0,0, A_RS1, B_RS2, 4'd0, 0, 2'd0, 1, 0), CARE_NO_ALU);
    step("mdwait 1", 0, 0, 0, S_ZERO, CARE_NO_ALU);
    step("mdwait 2", 0, 0, 0, S_ZERO, CARE_NO_ALU);
    step("mdwait 3", 0, 0, 1, S_ZERO, CARE_NO_ALU);
    step("mul wb",   0, 0, 0, E(0,0,0,0,0,0, 2'd0, 2'd0, 4'd0, 1, 2'd3, 0, 0), CARE_NO_ALU);
    do_fetch("after mul", I_ADDI5, 0, 7, 32'h0);
`else
    step("mul trap 1", 1, 0, 1, E(0,0,0,0,0,0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 0, 1), CARE_NO_ALU);
    step("mul trap 2", 1, 0, 1, E(0,0,0,0,0,0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 0, 1), CARE_NO_ALU);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
